mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 64: data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256: WAIT-state cycle limit, used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk  in  1  clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester request valid.
REQ-008 SHALL have port req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port req_we  in  NUM_REQ  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  in  NUM_REQ x ADDR_W  request addresses.
REQ-011 SHALL have port req_wdata  in  NUM_REQ x DATA_W  write data.
REQ-012 SHALL have port resp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-013 SHALL have port resp_rdata  out  DATA_W  read data, shared by all requesters.
REQ-014 SHALL have port resp_err  out  1  error flag, qualified by resp_valid.
REQ-015 SHALL have ports mem_valid out 1, mem_ready in 1, mem_we out 1, mem_addr out ADDR_W and mem_wdata out DATA_W: the memory command channel.
REQ-016 SHALL have ports mem_resp_valid in 1 and mem_rdata in DATA_W: memory completion, for both reads and write acks.

Function
REQ-017 SHALL implement FSM states ARB_IDLE, ARB_ISSUE, ARB_WAIT.
REQ-018 ARB_IDLE, any req_valid high:
- grant the requester chosen round-robin, starting from last_grant+1 mod NUM_REQ;
- assert req_ready[g] combinationally in that same cycle;
- latch we/addr/wdata and g;
- go to ARB_ISSUE.
REQ-019 ARB_ISSUE:
- drive mem_valid=1 with the latched fields, held stable until mem_ready;
- on mem_valid&&mem_ready, go to ARB_WAIT.
REQ-020 ARB_WAIT, on mem_resp_valid:
- register mem_rdata into resp_rdata (0 for writes);
- pulse resp_valid[g] on the next cycle;
- set last_grant=g;
- go to ARB_IDLE.
REQ-021 SHALL allow only one outstanding transaction; req_ready SHALL be all-zero outside ARB_IDLE.
REQ-022 Minimum latency: accept at cycle N, mem_valid at N+1; with mem_ready and mem_resp_valid immediate, resp_valid at N+3.
REQ-023 SHALL ignore mem_resp_valid in ARB_IDLE and ARB_ISSUE.
REQ-024 SHALL remain in ARB_ISSUE indefinitely while mem_ready is low, unless the timeout of REQ-030 applies.
REQ-025 A sole active requester SHALL be granted on every ARB_IDLE visit; with all requesters active, grants SHALL rotate 0,1,...,NUM_REQ-1,0.
REQ-026 SHALL ignore req_valid deassertion by non-granted requesters; requests are not latched until accepted.

Reset
REQ-027 On rst, SHALL set: state=ARB_IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 rst during ARB_ISSUE or ARB_WAIT SHALL abandon the transaction without any resp_valid; a later mem_resp_valid SHALL be ignored per REQ-023.

Configuration
REQ-029 SHALL use macro MEM_ARB_TIMEOUT_EN.
REQ-030 With MEM_ARB_TIMEOUT_EN defined:
- count cycles spent in ARB_ISSUE+ARB_WAIT;
- at TIMEOUT_CYCLES, pulse resp_valid[g] with resp_err=1 and resp_rdata=0, drop mem_valid, go to ARB_IDLE;
- counter SHALL clear on every ARB_IDLE entry.
REQ-031 Without MEM_ARB_TIMEOUT_EN: no counter SHALL exist and resp_err SHALL be tied 0.

Structure
REQ-032 SHALL place arb_state_t (ARB_IDLE/ARB_ISSUE/ARB_WAIT) and a mem_req_t struct (we, addr, wdata) in the shared package types.
REQ-033 SHALL implement the grant selection as sub-module rr_select: combinational inputs req_valid and last_grant, outputs one-hot grant and index.

Verification
REQ-034 Reset: rst high 2 cycles -> all outputs 0, state ARB_IDLE.
REQ-035 Read, NUM_REQ=2: req0 read at addr 0x100; memory returns 0xDEAD_BEEF with immediate ready/resp -> resp_valid[0] at N+3, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-036 Fairness: both requesters held valid for 6 transactions -> grant sequence 0,1,0,1,0,1.
REQ-037 Backpressure: mem_ready low 10 cycles -> mem_valid, mem_addr and mem_wdata stable throughout, req_ready all 0, exactly one completion.
REQ-038 Reset mid-op: rst asserted in ARB_WAIT, then mem_resp_valid arrives -> no resp_valid pulse; next request completes normally.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES=16): no mem_resp_valid -> resp_valid[g] with resp_err=1 sixteen cycles after acceptance; a late mem_resp_valid is ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and the latched command.
package mem_arbiter_pkg;

  // Upper bounds for the latched command; instances use the low ADDR_W/DATA_W bits.
  localparam int unsigned MEM_ADDR_W_MAX = 64;
  localparam int unsigned MEM_DATA_W_MAX = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_W_MAX-1:0] addr;
    logic [MEM_DATA_W_MAX-1:0] wdata;
  } mem_req_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Round-robin grant selection: first valid requester after last_grant, wrapping.
module rr_select
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  // Scan from farthest to nearest so the nearest valid requester is written last.
  always_comb begin
    grant = '0;
    index = '0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      int unsigned c;
      c = (32'(last_grant) + i) % NUM_REQ;
      if (req_valid[c]) begin
        grant = NUM_REQ'(1) << c;
        index = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for N requesters onto one memory port, one transaction in flight.
// Optional WAIT timeout with error response when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_t         state, state_nxt;
  mem_req_t           cmd;
  logic [IDX_W-1:0]   gnt_idx, last_grant, sel_idx;
  logic [NUM_REQ-1:0] sel_grant;
  logic               accept, complete, timeout;
  logic               unused_cmd;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (sel_grant),
    .index      (sel_idx)
  );

  assign accept     = (state == ARB_IDLE) && (|req_valid);
  assign complete   = (state == ARB_WAIT) && mem_resp_valid;
  assign mem_valid  = (state == ARB_ISSUE);
  assign mem_we     = cmd.we;
  assign mem_addr   = cmd.addr[ADDR_W-1:0];
  assign mem_wdata  = cmd.wdata[DATA_W-1:0];
  assign unused_cmd = ^cmd;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ARB_IDLE: begin
        if (|req_valid) begin
          req_ready = sel_grant;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: if (mem_ready)      state_nxt = ARB_WAIT;
      ARB_WAIT:  if (mem_resp_valid) state_nxt = ARB_IDLE;
      default:                       state_nxt = ARB_IDLE;
    endcase
    if (timeout) state_nxt = ARB_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      cmd        <= '0;
      gnt_idx    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= '0;
      if (accept) begin
        gnt_idx                 <= sel_idx;
        cmd.we                  <= req_we[sel_idx];
        cmd.addr[ADDR_W-1:0]    <= req_addr[sel_idx*ADDR_W +: ADDR_W];
        cmd.wdata[DATA_W-1:0]   <= req_wdata[sel_idx*DATA_W +: DATA_W];
      end
      if (complete || timeout) begin
        resp_valid <= NUM_REQ'(1) << gnt_idx;
        resp_rdata <= (cmd.we || timeout) ? '0 : mem_rdata;
        last_grant <= gnt_idx;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  // Counter is 0 in the first ISSUE cycle; firing at TIMEOUT_CYCLES-2 lands the
  // registered error pulse exactly TIMEOUT_CYCLES cycles after acceptance.
  assign timeout = (state != ARB_IDLE) && !complete &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_err <= timeout;
      if (state == ARB_IDLE || state_nxt == ARB_IDLE) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif

endmodule
